// File: rtl/lsu_pkg.sv
// Shared size encodings, FSM states and lane helpers for the LSU RAM port.
// Used by lsu_ram_port and lsu_load_align.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } lsu_state_t;

    function automatic logic [3:0] lane_mask(
        input logic [1:0] sz,
        input logic [1:0] lo
    );
        logic [3:0] m;
        unique case (1'b1)
            sz == SZ_B: m = 4'b0001 << lo;
            sz == SZ_H: m = 4'b0011 << {lo[1], 1'b0};
            default:    m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_rep(
        input logic [1:0]  sz,
        input logic [31:0] wd
    );
        logic [31:0] r;
        unique case (1'b1)
            sz == SZ_B: r = {4{wd[7:0]}};
            sz == SZ_H: r = {2{wd[15:0]}};
            default:    r = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_ram_port_if.sv
// Request/response and byte-lane RAM bundle for the LSU RAM port.
// master = core/RAM side, slave = the LSU port itself.
interface lsu_ram_port_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [3:0]    ram_wen;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_wdata;
    logic          ram_ren;
    logic [DW-1:0] ram_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata, rsp_ready, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ram_wen, ram_waddr, ram_raddr, ram_wdata, ram_ren
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata, rsp_ready, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ram_wen, ram_waddr, ram_raddr, ram_wdata, ram_ren
    );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed lane(s) of a RAM word and sign/zero extends them.
// Purely combinational.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    lo,
    input  logic [1:0]    size,
    input  logic          uns,
    output logic [DW-1:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = 8'h00;
        unique case (lo)
            2'd0: b = rdata[7:0];
            2'd1: b = rdata[15:8];
            2'd2: b = rdata[23:16];
            2'd3: b = rdata[31:24];
            default: b = 8'h00;
        endcase
    end

    assign h = lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        unique case (1'b1)
            size == SZ_B: data = {{24{~uns & b[7]}}, b};
            size == SZ_H: data = {{16{~uns & h[15]}}, h};
            default:      data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ram_port.sv
// Single-outstanding LSU port onto a byte-lane RAM with 1-cycle read latency.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned and reserved-size accesses.
module lsu_ram_port
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [3:0]    ram_wen,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_ren,
    input  logic [DW-1:0] ram_rdata
);

    lsu_state_t    state_q, state_d;
    logic [1:0]    lo_q, lo_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          fire;
    logic          bad;
    logic [DW-1:0] ld_data;

    // Ready is masked by reset so no strobe can leak out while rstn is low.
    assign req_ready = (state_q == IDLE) & rstn;
    assign fire      = req_valid & req_ready;

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        bad = 1'b0;
        unique case (1'b1)
            req_size == SZ_H: bad = req_addr[0];
            req_size == SZ_W: bad = |req_addr[1:0];
            req_size == SZ_R: bad = 1'b1;
            default:          bad = 1'b0;
        endcase
    end
`else
    assign bad = 1'b0;
`endif

    assign ram_waddr = req_addr;
    assign ram_raddr = req_addr;
    assign ram_wdata = lane_rep(req_size, req_wdata);

    lsu_load_align #(.DW(DW)) u_align (
        .rdata (ram_rdata),
        .lo    (lo_q),
        .size  (size_q),
        .uns   (uns_q),
        .data  (ld_data)
    );

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ram_wen = 4'b0000;
        ram_ren = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    rdata_d = '0;
                    err_d   = bad;
                    if (bad) begin
                        state_d = RESP;
                    end else if (req_we) begin
                        ram_wen = lane_mask(req_size, req_addr[1:0]);
                        state_d = RESP;
                    end else begin
                        ram_ren = 1'b1;
                        lo_d    = req_addr[1:0];
                        size_d  = req_size;
                        uns_d   = req_unsigned;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                rdata_d = ld_data;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            lo_q    <= 2'b00;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
